// File: rtl/packet_decoder.sv
// packet_decoder: rebuilds a packet word from the generator's byte stream.
// ASCII-hex framing (BINARY=0): PACKET_SIZE/4 hex chars followed by CR; LF is ignored.
// Raw binary framing (BINARY=1): PACKET_SIZE/8 bytes, no terminator.
// Optional macro PACKET_DECODER_FIELDS_EN adds registered header/footer field outputs.
// PACKET_SIZE must be a multiple of 8 and at least 128.
module packet_decoder #(
    parameter int unsigned PACKET_SIZE = 192,
    parameter bit          BINARY      = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [7:0]                      rx_byte,
    input  logic                            rx_valid,
    output logic [PACKET_SIZE-1:0]          packet,
    output logic                            packet_valid,
    output logic                            frame_error,
    output logic [1:0]                      error_code,
    output logic [$clog2(PACKET_SIZE/4):0]  nibble_count
`ifdef PACKET_DECODER_FIELDS_EN
    ,
    output logic [7:0]                      resolution,
    output logic [23:0]                     num_inputs,
    output logic [4:0]                      lag_auto,
    output logic [4:0]                      lag_cross,
    output logic [7:0]                      flags,
    output logic [15:0]                     tick,
    output logic [63:0]                     timestamp
`endif
);

    localparam int unsigned PW      = PACKET_SIZE;
    localparam int unsigned NIBBLES = PACKET_SIZE / 4;
    localparam int unsigned CW      = $clog2(NIBBLES) + 1;
    localparam int unsigned STEP    = BINARY ? 2 : 1;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
    localparam logic [1:0] ERR_SHORT    = 2'd2;
    localparam logic [1:0] ERR_LONG     = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WAIT_EOL,
        DONE,
        DISCARD
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   shreg, shreg_nxt;
    logic [PW-1:0]   packet_nxt;
    logic            packet_valid_nxt;
    logic            frame_error_nxt;
    logic [1:0]      error_code_nxt;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   count_inc;
    logic [4:0]      hex;
    logic            is_cr;
    logic            is_lf;

    // Returns {valid, nibble} for an ASCII hex character.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, 4'(c[3:0] + 4'd9)};
        end
        return r;
    endfunction

    // Character classification and saturating nibble counter increment.
    always_comb begin
        hex       = hex_decode(rx_byte);
        is_cr     = (rx_byte == CHAR_CR);
        is_lf     = (rx_byte == CHAR_LF);
        count_inc = nibble_count + CW'(STEP);
        if (count_inc >= CW'(NIBBLES)) begin
            count_inc = CW'(NIBBLES);
        end
    end

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_nxt        = state;
        shreg_nxt        = shreg;
        packet_nxt       = packet;
        packet_valid_nxt = 1'b0;
        frame_error_nxt  = 1'b0;
        error_code_nxt   = error_code;
        count_nxt        = nibble_count;

        if (!enable) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                // DONE consumes no byte, so it behaves exactly like IDLE for input.
                IDLE, DONE: begin
                    state_nxt = IDLE;
                    if (rx_valid) begin
                        if (BINARY) begin
                            shreg_nxt = PW'(rx_byte);
                            count_nxt = CW'(2);
                            state_nxt = RECV;
                        end else if (hex[4]) begin
                            shreg_nxt = PW'(hex[3:0]);
                            count_nxt = CW'(1);
                            state_nxt = RECV;
                        end
                    end
                end

                RECV: begin
                    if (rx_valid) begin
                        if (BINARY) begin
                            shreg_nxt = {shreg[PW-9:0], rx_byte};
                            count_nxt = count_inc;
                            if (count_inc == CW'(NIBBLES)) begin
                                packet_nxt       = shreg_nxt;
                                packet_valid_nxt = 1'b1;
                                count_nxt        = '0;
                                state_nxt        = DONE;
                            end
                        end else if (is_lf) begin
                            state_nxt = RECV;
                        end else if (hex[4]) begin
                            shreg_nxt = {shreg[PW-5:0], hex[3:0]};
                            count_nxt = count_inc;
                            if (count_inc == CW'(NIBBLES)) begin
                                state_nxt = WAIT_EOL;
                            end
                        end else if (is_cr) begin
                            frame_error_nxt = 1'b1;
                            error_code_nxt  = ERR_SHORT;
                            count_nxt       = '0;
                            state_nxt       = IDLE;
                        end else begin
                            frame_error_nxt = 1'b1;
                            error_code_nxt  = ERR_BAD_CHAR;
                            count_nxt       = '0;
                            state_nxt       = DISCARD;
                        end
                    end
                end

                WAIT_EOL: begin
                    if (rx_valid && !is_lf) begin
                        if (is_cr) begin
                            packet_nxt       = shreg;
                            packet_valid_nxt = 1'b1;
                            count_nxt        = '0;
                            state_nxt        = DONE;
                        end else begin
                            frame_error_nxt = 1'b1;
                            error_code_nxt  = hex[4] ? ERR_LONG : ERR_BAD_CHAR;
                            count_nxt       = '0;
                            state_nxt       = DISCARD;
                        end
                    end
                end

                DISCARD: begin
                    if (rx_valid && is_cr) begin
                        state_nxt = IDLE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            packet       <= '0;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
            error_code   <= 2'd0;
            nibble_count <= '0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            packet       <= packet_nxt;
            packet_valid <= packet_valid_nxt;
            frame_error  <= frame_error_nxt;
            error_code   <= error_code_nxt;
            nibble_count <= count_nxt;
        end
    end

`ifdef PACKET_DECODER_FIELDS_EN
    // Header/footer fields, captured on the same edge as packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resolution <= 8'd0;
            num_inputs <= 24'd0;
            lag_auto   <= 5'd0;
            lag_cross  <= 5'd0;
            flags      <= 8'd0;
            tick       <= 16'd0;
            timestamp  <= 64'd0;
        end else if (packet_valid_nxt) begin
            resolution <= packet_nxt[PW-1 -: 8];
            num_inputs <= packet_nxt[PW-9 -: 24] + 24'd1;
            lag_auto   <= 5'(packet_nxt[PW-33 -: 4]) + 5'd1;
            lag_cross  <= 5'(packet_nxt[PW-37 -: 4]) + 5'd1;
            flags      <= packet_nxt[PW-41 -: 8];
            tick       <= packet_nxt[PW-49 -: 16];
            timestamp  <= packet_nxt[63:0];
        end
    end
`endif

endmodule

// File: tb/tb_packet_decoder.sv
// Directed bench for packet_decoder: one ASCII instance and one binary instance.
// Field outputs are checked when PACKET_DECODER_FIELDS_EN is defined.
module tb_packet_decoder;

    logic         clk;
    logic         reset;

    logic         en_a, valid_a;
    logic [7:0]   byte_a;
    logic [191:0] packet_a;
    logic         pv_a, fe_a;
    logic [1:0]   ec_a;
    logic [6:0]   nc_a;

    logic         en_b, valid_b;
    logic [7:0]   byte_b;
    logic [191:0] packet_b;
    logic         pv_b, fe_b;
    logic [1:0]   ec_b;
    logic [6:0]   nc_b;

`ifdef PACKET_DECODER_FIELDS_EN
    logic [7:0]  res_a, res_b, flags_a, flags_b;
    logic [23:0] num_a, num_b;
    logic [4:0]  la_a, la_b, lc_a, lc_b;
    logic [15:0] tick_a, tick_b;
    logic [63:0] ts_a, ts_b;
`endif

    int checks = 0;
    int errors = 0;
    int fe_cnt_a = 0;

    packet_decoder #(.PACKET_SIZE(192), .BINARY(1'b0)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .rx_byte(byte_a), .rx_valid(valid_a),
        .packet(packet_a), .packet_valid(pv_a), .frame_error(fe_a),
        .error_code(ec_a), .nibble_count(nc_a)
`ifdef PACKET_DECODER_FIELDS_EN
        , .resolution(res_a), .num_inputs(num_a), .lag_auto(la_a), .lag_cross(lc_a),
        .flags(flags_a), .tick(tick_a), .timestamp(ts_a)
`endif
    );

    packet_decoder #(.PACKET_SIZE(192), .BINARY(1'b1)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .rx_byte(byte_b), .rx_valid(valid_b),
        .packet(packet_b), .packet_valid(pv_b), .frame_error(fe_b),
        .error_code(ec_b), .nibble_count(nc_b)
`ifdef PACKET_DECODER_FIELDS_EN
        , .resolution(res_b), .num_inputs(num_b), .lag_auto(la_b), .lag_cross(lc_b),
        .flags(flags_b), .tick(tick_b), .timestamp(ts_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_error pulses on the ASCII instance.
    always @(posedge clk) begin
        if (fe_a) fe_cnt_a = fe_cnt_a + 1;
    end

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte per cycle; consecutive calls keep rx_valid high across edges.
    task automatic send_a(input logic [7:0] b);
        byte_a  = b;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        byte_b  = b;
        valid_b = 1'b1;
        @(posedge clk);
        #1;
        valid_b = 1'b0;
    endtask

    task automatic send_str_a(input string s);
        for (int i = 0; i < s.len(); i++) send_a(s[i]);
    endtask

    task automatic idle_cycle;
        @(posedge clk);
        #1;
    endtask

    logic [191:0] exp1, exp2, exp3, exp_b, exp_f;
    int fe_start;

    initial begin
        exp1 = 192'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
        exp2 = 192'hFEDCBA9876543210FEDCBA9876543210FEDCBA9876543210;
        exp3 = 192'hDEADBEEFCAFEF00DDEADBEEFCAFEF00DDEADBEEFCAFEF00D;
        exp_b = {24{8'hA5}};
        exp_f = {64'h1800000700052710, 64'h0, 64'h0102030405060708};

        reset = 1'b1; en_a = 1'b1; en_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0; byte_a = 8'h00; byte_b = 8'h00;
        #12;
        check("rst_packet", packet_a, 0);
        check("rst_pv", pv_a, 0);
        check("rst_fe", fe_a, 0);
        check("rst_ec", ec_a, 0);
        check("rst_nc", nc_a, 0);
        check("rst_packet_b", packet_b, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();

        // Good ASCII frame, with CR right after the last char.
        fe_start = fe_cnt_a;
        send_str_a("0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF");
        check("good1_nc_sat", nc_a, 48);
        send_a(8'h0D);
        check("good1_pv", pv_a, 1);
        check("good1_packet", packet_a, exp1);
        check("good1_nc_clr", nc_a, 0);
        idle_cycle();
        check("good1_pv_pulse", pv_a, 0);
        check("good1_no_err", fe_cnt_a - fe_start, 0);

        // Short frame: 20 chars then CR.
        send_str_a("FEDCBA9876543210FEDC");
        check("short_nc", nc_a, 20);
        send_a(8'h0D);
        check("short_fe", fe_a, 1);
        check("short_ec", ec_a, 2);
        check("short_pv", pv_a, 0);
        check("short_packet", packet_a, exp1);
        idle_cycle();
        check("short_fe_pulse", fe_a, 0);
        check("short_ec_hold", ec_a, 2);

        // Lowercase frame with embedded LF decodes correctly.
        send_str_a("fedcba9876543210");
        send_a(8'h0A);
        send_str_a("fedcba9876543210fedcba9876543210");
        send_a(8'h0D);
        check("lower_pv", pv_a, 1);
        check("lower_packet", packet_a, exp2);
        idle_cycle();

        // Long frame: 49th hex char.
        send_str_a("0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF");
        send_a("7");
        check("long_fe", fe_a, 1);
        check("long_ec", ec_a, 3);
        send_a(8'h0D);
        check("long_pv", pv_a, 0);
        check("long_packet", packet_a, exp2);

        // Bad char mid-frame, rest discarded until CR.
        send_str_a("12345");
        send_a("G");
        check("bad_fe", fe_a, 1);
        check("bad_ec", ec_a, 1);
        send_str_a("89");
        send_a(8'h0D);
        check("discard_pv", pv_a, 0);
        check("discard_fe", fe_a, 0);
        check("discard_packet", packet_a, exp2);
        idle_cycle();

        // Reset after 10 chars.
        send_str_a("0123456789");
        reset = 1'b1;
        #1;
        check("mid_rst_packet", packet_a, 0);
        check("mid_rst_nc", nc_a, 0);
        check("mid_rst_ec", ec_a, 0);
        check("mid_rst_pv", pv_a, 0);
        idle_cycle();
        reset = 1'b0;
        send_str_a("DEADBEEFCAFEF00DDEADBEEFCAFEF00DDEADBEEFCAFEF00D");
        send_a(8'h0D);
        check("post_rst_pv", pv_a, 1);
        check("post_rst_packet", packet_a, exp3);
        idle_cycle();

        // enable drop mid-frame, with a simultaneous strobe that must be dropped.
        fe_start = fe_cnt_a;
        send_str_a("ABCDEFABCD");
        en_a = 1'b0;
        send_a("1");
        check("en_drop_nc", nc_a, 0);
        check("en_drop_fe", fe_a, 0);
        en_a = 1'b1;
        send_str_a("0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF");
        send_a(8'h0D);
        check("en_next_pv", pv_a, 1);
        check("en_next_packet", packet_a, exp1);
        check("en_no_err", fe_cnt_a - fe_start, 0);
        idle_cycle();

        // Binary: 24 bytes back to back, then a 25th starts a new frame.
        for (int i = 0; i < 24; i++) begin
            send_b(8'hA5);
            if (i == 11) check("bin_nc_half", nc_b, 24);
        end
        check("bin_pv", pv_b, 1);
        check("bin_packet", packet_b, exp_b);
        check("bin_fe", fe_b, 0);
        send_b(8'hA5);
        check("bin_next_nc", nc_b, 2);
        check("bin_next_pv", pv_b, 0);
        en_b = 1'b0;
        idle_cycle();
        en_b = 1'b1;

        // Binary header/footer frame.
        begin
            logic [7:0] hdr [8];
            hdr = '{8'h18, 8'h00, 8'h00, 8'h07, 8'h00, 8'h05, 8'h27, 8'h10};
            for (int i = 0; i < 8; i++) send_b(hdr[i]);
            for (int i = 0; i < 8; i++) send_b(8'h00);
            for (int i = 0; i < 8; i++) send_b(8'(i + 1));
        end
        check("fld_pv", pv_b, 1);
        check("fld_packet", packet_b, exp_f);
`ifdef PACKET_DECODER_FIELDS_EN
        check("fld_resolution", res_b, 24);
        check("fld_num_inputs", num_b, 8);
        check("fld_lag_auto", la_b, 1);
        check("fld_lag_cross", lc_b, 1);
        check("fld_flags", flags_b, 5);
        check("fld_tick", tick_b, 10000);
        check("fld_timestamp", ts_b, 64'h0102030405060708);
        check("fld_a_resolution", res_a, 8'h01);
`endif
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_decoder.md
# packet_decoder

Receive-side counterpart of the correlator packet generator. Consumes the byte stream the packet generator emits (one byte per strobe from a UART or SPI receiver), rebuilds the full packet word, and presents it with a one-cycle valid pulse. With the field option enabled, it also splits out the header and footer fields. It is used in loopback self-test and in chained-correlator builds, where one board ingests another board's packets.

## Interface

- PACKET_SIZE, 192: packet width in bits. Must be a multiple of 8 and at least 128.
- BINARY, 0: 0 = ASCII-hex framing; 1 = raw binary framing.

- clk  input  1  sole clock; all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- enable  input  1  level; low forces IDLE and discards any partial frame.
- rx_byte  input  8  received byte, valid only while rx_valid is high.
- rx_valid  input  1  one-cycle strobe, synchronous to clk; at most one byte per cycle.
- packet  output  PACKET_SIZE  last good packet, MSB = first nibble received.
- packet_valid  output  1  one-cycle pulse when packet updates.
- frame_error  output  1  one-cycle pulse on a rejected frame.
- error_code  output  2  cause of last error: 1 bad char, 2 short frame, 3 long frame; holds until next error.
- nibble_count  output  clog2(PACKET_SIZE/4)+1  nibbles accepted in the current frame.

## Operation

- ASCII mode (BINARY=0):
  - Each nibble is one character: '0'-'9', 'A'-'F' or 'a'-'f'.
  - Most significant nibble first; exactly PACKET_SIZE/4 characters, then CR (0x0D).
  - LF (0x0A) is ignored in every state.
- Binary mode (BINARY=1):
  - Each byte carries two nibbles, high nibble first.
  - The frame completes on byte PACKET_SIZE/8. There is no terminator.
- Shift register: nibbles shift into an internal register `shreg` (shift left by 4, new nibble in bits [3:0]). `packet` copies `shreg` only on a good frame, so a partial or failed frame never disturbs `packet`.
- States:
  - IDLE → RECV on the first valid nibble (clear `shreg`, load the nibble, nibble_count=1). A CR in IDLE is ignored.
  - RECV:
    - Valid nibble: shift it in and increment nibble_count.
    - Count reaches PACKET_SIZE/4: ASCII → WAIT_EOL; binary → DONE.
    - Invalid char: error 1 → DISCARD.
    - CR: error 2 → IDLE.
  - WAIT_EOL:
    - CR → DONE.
    - Hex char: error 3 → DISCARD.
    - Other char: error 1 → DISCARD.
  - DONE: `packet`<=`shreg`, pulse packet_valid, → IDLE, nibble_count=0.
  - DISCARD: drop everything until CR, then → IDLE. Binary mode never enters DISCARD.
- enable low in any state → IDLE, nibble_count=0, no error pulse.
- reset mid-frame: immediate return to IDLE; all outputs 0.

## Timing

- Reset values: packet=0, packet_valid=0, frame_error=0, error_code=0, nibble_count=0.
- Latency:
  - packet_valid rises exactly 1 cycle after the rx_valid cycle carrying the CR (ASCII) or the final byte (binary).
  - `packet` is stable from that same edge until the next good frame.
- frame_error pulses 1 cycle after the offending byte; error_code updates on the same edge.
- Back-to-back strobes (rx_valid high every cycle) are fully supported. DONE takes no byte, so a byte arriving in the DONE cycle is processed as the first byte of the next frame from IDLE.
- Simultaneous enable fall and rx_valid: enable wins; the byte is dropped.
- nibble_count saturates at PACKET_SIZE/4; it never wraps.

## Configuration

- PACKET_DECODER_FIELDS_EN defined: adds registered outputs, updated on the same edge as `packet`. Bit positions are counted from the top of the packet:
  - resolution[7:0] = packet[top 8].
  - num_inputs[23:0] = next 24 bits + 1.
  - lag_auto[4:0] = next 4 bits + 1.
  - lag_cross[4:0] = next 4 bits + 1.
  - flags[7:0] = next 8 bits (bit0 crosscorrelator, bit1 leds, bit2 psu, bit3 cumulative-only).
  - tick[15:0] = next 16 bits.
  - timestamp[63:0] = packet[63:0].
  - All reset to 0.
- Not defined: these ports and registers are absent; the decoder emits only the raw packet.

## Test plan

- ASCII, PACKET_SIZE=192: send 48 chars "0123456789ABCDEF" ×3 then CR → packet=192'h0123456789ABCDEF×3, packet_valid one cycle after CR, frame_error never set.
- ASCII, 20 hex chars then CR → frame_error, error_code=2, packet unchanged; the following good frame decodes correctly.
- ASCII, 48 chars, then '7', then CR → error_code=3, DISCARD, packet unchanged. A 'G' mid-frame → error_code=1; bytes until CR are ignored.
- BINARY=1, 24 bytes 0xA5 with rx_valid held high continuously → packet = 0xA5 repeated, packet_valid one cycle after byte 24. A 25th byte starts a new frame (nibble_count=2).
- Reset asserted after 10 chars, then a full good frame → all outputs 0 during reset, then correct packet. enable dropped mid-frame → no error, next frame good.
- With PACKET_DECODER_FIELDS_EN, top 64 bits = 0x18_000007_0_0_05_2710 → resolution=24, num_inputs=8, lag_auto=1, lag_cross=1, flags=5, tick=10000.
